fft_agu_pipe: RTL and testbench

//  Parametrised radix-2 DIT FFT address generator with pipeline-aware write-back.
//  - Issues butterfly read addresses, scaled twiddle indices, and latency-matched write addresses.
//  - Handles NUM_CH independent frames per run and back-pressure from the butterfly.
//  - Sits between the FFT controller and the ping-pong sample RAMs / butterfly datapath.

---
 rtl/fft_consts.sv | 24 ++
 rtl/fft_agu_wr_pipe.sv | 70 +++++++
 rtl/fft_agu_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_fft_agu_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_consts.sv
// Shared types and helpers for the FFT address generator: FSM state encoding and
// a bit-reversal function usable at any width up to 32 bits.
package fft_consts;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_SWAIT = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } agu_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[5'(w - 1 - i)] = v[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_agu_wr_pipe.sv
// Write-back delay line for the FFT AGU: replays each accepted read pair LAT cycles
// later and tracks how many writes are still in flight.
module fft_agu_wr_pipe #(
  parameter int AW  = 11,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic          bank_i,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic          wr_bank,
  output logic          empty
);

  localparam int CW = $clog2(LAT + 2);

  logic [LAT-1:0] v_q, v_d, bk_q, bk_d;
  logic [AW-1:0]  a_q [LAT];
  logic [AW-1:0]  a_d [LAT];
  logic [AW-1:0]  b_q [LAT];
  logic [AW-1:0]  b_d [LAT];
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    v_d[0]  = acc_i;
    bk_d[0] = bank_i;
    a_d[0]  = addr_a_i;
    b_d[0]  = addr_b_i;
    for (int i = 1; i < LAT; i++) begin
      v_d[i]  = v_q[i-1];
      bk_d[i] = bk_q[i-1];
      a_d[i]  = a_q[i-1];
      b_d[i]  = b_q[i-1];
    end
    cnt_d = cnt_q + CW'(acc_i) - CW'(v_q[LAT-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      bk_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      bk_q  <= bk_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LAT; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
    end
  end

  assign wr_valid  = v_q[LAT-1];
  assign wr_bank   = bk_q[LAT-1];
  assign wr_addr_a = a_q[LAT-1];
  assign wr_addr_b = b_q[LAT-1];
  // "Empty after this cycle": lets the FSM leave a wait state on the last write itself.
  assign empty     = (cnt_d == '0);

endmodule

// File: rtl/fft_agu_pipe.sv
// Radix-2 DIT FFT address generator with latency-matched write-back and per-stage bank
// ping-pong. Define FFT_AGU_BITREV_LOAD_EN to add a bit-reversed input load phase.
// Handshake: a read pair is accepted on a cycle with rd_valid && bfly_ready; while
// not accepted, every rd_* output holds. ld_* follows the same rule with ld_ready.
module fft_agu_pipe
  import fft_consts::*;
#(
  parameter int N_LOG2   = 10,
  parameter int NUM_CH   = 1,
  parameter int BFLY_LAT = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW      = N_LOG2 + CH_W,
  localparam int SW      = $clog2(N_LOG2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bfly_ready,
  output logic              rd_valid,
  output logic [AW-1:0]     rd_addr_a,
  output logic [AW-1:0]     rd_addr_b,
  output logic [N_LOG2-2:0] twiddle_idx,
  output logic [SW-1:0]     stage,
  output logic              rd_bank,
  output logic              wr_valid,
  output logic [AW-1:0]     wr_addr_a,
  output logic [AW-1:0]     wr_addr_b,
  output logic              wr_bank,
  output logic              busy,
  output logic              done,
  output logic              final_bank,
`ifdef FFT_AGU_BITREV_LOAD_EN
  input  logic              ld_ready,
  output logic              ld_valid,
  output logic [AW-1:0]     ld_addr,
`endif
  output agu_state_t        dbg_state
);

  localparam int HW = N_LOG2 - 1;

  agu_state_t        state_q, state_d;
  logic [HW-1:0]     p_q, p_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic              bank_q, bank_d, fbank_q, fbank_d;
  logic [N_LOG2-1:0] p_ext, idx_a, idx_b;
  logic [HW-1:0]     j, tw;
  int unsigned       st;
  logic              acc, ch_last, p_last, stage_last, wr_empty;
`ifdef FFT_AGU_BITREV_LOAD_EN
  logic [N_LOG2-1:0] ln_q, ln_d;
  logic              ld_acc;
`endif

  assign rd_valid   = (state_q == ST_RUN);
  assign acc        = rd_valid && bfly_ready;
  assign ch_last    = (ch_q == CH_W'(NUM_CH - 1));
  assign p_last     = &p_q;
  assign stage_last = (stage_q == SW'(N_LOG2 - 1));

  // Pair index p walks groups then j; inserting a zero at bit 'stage' yields the upper operand.
  always_comb begin
    st    = 32'(stage_q);
    p_ext = {1'b0, p_q};
    idx_a = ((p_ext >> st) << (st + 1)) | (p_ext & ((N_LOG2'(1) << st) - N_LOG2'(1)));
    idx_b = idx_a + (N_LOG2'(1) << st);
    j     = p_q & ((HW'(1) << st) - HW'(1));
    tw    = j << (32'(HW) - st);
  end

  assign rd_addr_a   = rd_valid ? {ch_q, idx_a} : '0;
  assign rd_addr_b   = rd_valid ? {ch_q, idx_b} : '0;
  assign twiddle_idx = rd_valid ? tw : '0;
  assign stage       = stage_q;
  assign rd_bank     = bank_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign final_bank  = fbank_q;
  assign dbg_state   = state_q;

`ifdef FFT_AGU_BITREV_LOAD_EN
  assign ld_valid = (state_q == ST_LOAD);
  assign ld_acc   = ld_valid && ld_ready;
  assign ld_addr  = ld_valid ? {ch_q, N_LOG2'(bitrev(32'(ln_q), N_LOG2))} : '0;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ch_d    = ch_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    fbank_d = fbank_q;
`ifdef FFT_AGU_BITREV_LOAD_EN
    ln_d    = ln_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          p_d     = '0;
          ch_d    = '0;
          stage_d = '0;
          bank_d  = 1'b0;
`ifdef FFT_AGU_BITREV_LOAD_EN
          ln_d    = '0;
          state_d = ST_LOAD;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef FFT_AGU_BITREV_LOAD_EN
      ST_LOAD: begin
        if (ld_acc) begin
          ln_d = ln_q + N_LOG2'(1);
          if (&ln_q) begin
            ch_d = ch_q + CH_W'(1);
            if (ch_last) begin
              ch_d    = '0;
              state_d = ST_RUN;
            end
          end
        end
      end
`endif
      ST_RUN: begin
        if (acc) begin
          p_d = p_q + HW'(1);
          if (p_last) begin
            ch_d = ch_q + CH_W'(1);
            if (ch_last) begin
              ch_d = '0;
              if (stage_last) begin
                fbank_d = ~bank_q;
                state_d = ST_DRAIN;
              end else begin
                state_d = ST_SWAIT;
              end
            end
          end
        end
      end
      // Next stage reads only after the previous stage's final write has landed.
      ST_SWAIT: begin
        if (wr_valid && wr_empty) begin
          stage_d = stage_q + SW'(1);
          bank_d  = ~bank_q;
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (wr_valid && wr_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      ch_q    <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      fbank_q <= 1'b0;
`ifdef FFT_AGU_BITREV_LOAD_EN
      ln_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ch_q    <= ch_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      fbank_q <= fbank_d;
`ifdef FFT_AGU_BITREV_LOAD_EN
      ln_q    <= ln_d;
`endif
    end
  end

  fft_agu_wr_pipe #(
    .AW  (AW),
    .LAT (BFLY_LAT)
  ) u_wr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_i     (acc),
    .addr_a_i  (rd_addr_a),
    .addr_b_i  (rd_addr_b),
    .bank_i    (~bank_q),
    .wr_valid  (wr_valid),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_bank   (wr_bank),
    .empty     (wr_empty)
  );

endmodule

// File: tb/tb_fft_agu_pipe.sv
// Directed bench for fft_agu_pipe: u0 (N_LOG2=3, 1 ch, lat 2) and u1 (N_LOG2=2, 2 ch, lat 2).
// Covers reset, full-rate run, stalled run, multi-channel, async reset and busy start.
module tb_fft_agu_pipe;
  import fft_consts::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, rdy0 = 1'b0, start1 = 1'b0, rdy1 = 1'b0;

  logic       v0, bk0, wv0, wbk0, busy0, done0, fb0;
  logic [3:0] a0, b0, wa0, wb0;
  logic [1:0] tw0, st0;
  agu_state_t dbg0;

  logic       v1, bk1, wv1, wbk1, busy1, done1, fb1;
  logic [2:0] a1, b1, wa1, wb1;
  logic [0:0] tw1, st1;
  agu_state_t dbg1;

`ifdef FFT_AGU_BITREV_LOAD_EN
  logic       ldr = 1'b1;
  logic       ldv0, ldv1;
  logic [3:0] lda0;
  logic [2:0] lda1;
  localparam int LD0 = 8;
  int ld_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  localparam int LD0 = 0;
`endif

  fft_agu_pipe #(.N_LOG2(3), .NUM_CH(1), .BFLY_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bfly_ready(rdy0),
    .rd_valid(v0), .rd_addr_a(a0), .rd_addr_b(b0), .twiddle_idx(tw0),
    .stage(st0), .rd_bank(bk0), .wr_valid(wv0), .wr_addr_a(wa0),
    .wr_addr_b(wb0), .wr_bank(wbk0), .busy(busy0), .done(done0),
    .final_bank(fb0),
`ifdef FFT_AGU_BITREV_LOAD_EN
    .ld_ready(ldr), .ld_valid(ldv0), .ld_addr(lda0),
`endif
    .dbg_state(dbg0)
  );

  fft_agu_pipe #(.N_LOG2(2), .NUM_CH(2), .BFLY_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bfly_ready(rdy1),
    .rd_valid(v1), .rd_addr_a(a1), .rd_addr_b(b1), .twiddle_idx(tw1),
    .stage(st1), .rd_bank(bk1), .wr_valid(wv1), .wr_addr_a(wa1),
    .wr_addr_b(wb1), .wr_bank(wbk1), .busy(busy1), .done(done1),
    .final_bank(fb1),
`ifdef FFT_AGU_BITREV_LOAD_EN
    .ld_ready(ldr), .ld_valid(ldv1), .ld_addr(lda1),
`endif
    .dbg_state(dbg1)
  );

  // Hand-computed read sequences.
  int exp_a0[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b0[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw0[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int exp_a1[8]   = '{0, 2, 4, 6, 0, 1, 4, 5};
  int exp_b1[8]   = '{1, 3, 5, 7, 2, 3, 6, 7};
  int exp_tw1[8]  = '{0, 0, 0, 0, 0, 1, 0, 1};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-rate u0 timing: stage s reads at rel cycles 1+6s .. 4+6s.
  function automatic bit rd_cycle(input int rel, output int k);
    k = 0;
    if (rel < 1) return 1'b0;
    if ((rel - 1) / 6 > 2 || (rel - 1) % 6 > 3) return 1'b0;
    k = ((rel - 1) / 6) * 4 + (rel - 1) % 6;
    return 1'b1;
  endfunction

  task automatic check_u0_zero(input string tag);
    check({tag, "_rd_valid"}, 32'(v0), 0);
    check({tag, "_rd_a"}, 32'(a0), 0);
    check({tag, "_rd_b"}, 32'(b0), 0);
    check({tag, "_tw"}, 32'(tw0), 0);
    check({tag, "_stage"}, 32'(st0), 0);
    check({tag, "_rd_bank"}, 32'(bk0), 0);
    check({tag, "_wr_valid"}, 32'(wv0), 0);
    check({tag, "_wr_a"}, 32'(wa0), 0);
    check({tag, "_wr_b"}, 32'(wb0), 0);
    check({tag, "_busy"}, 32'(busy0), 0);
    check({tag, "_done"}, 32'(done0), 0);
    check({tag, "_final_bank"}, 32'(fb0), 0);
    check({tag, "_state"}, 32'(dbg0), 32'(ST_IDLE));
  endtask

  task automatic run_ref(input bit pulse_busy);
    int k, wk, rel;
    bit rv, wv;
    start0 = 1'b1;
    rdy0   = 1'b1;
    for (int c = 1; c <= LD0 + 20; c++) begin
      tick();
      start0 = pulse_busy && (c == 5 || c == 12);
      rel = c - LD0;
      rv = rd_cycle(rel, k);
      check("rd_valid", 32'(v0), 32'(rv));
      if (rv) begin
        check("rd_addr_a", 32'(a0), exp_a0[k]);
        check("rd_addr_b", 32'(b0), exp_b0[k]);
        check("twiddle", 32'(tw0), exp_tw0[k]);
        check("stage", 32'(st0), k / 4);
        check("rd_bank", 32'(bk0), (k / 4) % 2);
      end
      wv = rd_cycle(rel - 2, wk);
      check("wr_valid", 32'(wv0), 32'(wv));
      if (wv) begin
        check("wr_addr_a", 32'(wa0), exp_a0[wk]);
        check("wr_addr_b", 32'(wb0), exp_b0[wk]);
        check("wr_bank", 32'(wbk0), ((wk / 4) % 2 == 0) ? 1 : 0);
      end
      check("done", 32'(done0), (rel == 19) ? 1 : 0);
      check("busy", 32'(busy0), (rel <= 19) ? 1 : 0);
      if (rel == 19) check("final_bank", 32'(fb0), 1);
`ifdef FFT_AGU_BITREV_LOAD_EN
      check("ld_valid", 32'(ldv0), (c <= LD0) ? 1 : 0);
      if (c <= LD0) check("ld_addr", 32'(lda0), ld_tab[c-1]);
`endif
    end
  endtask

  task automatic run_stall();
    logic [8:0] exp_q[$];
    int due_q[$];
    logic [8:0] e;
    int k = 0, nw = 0;
    bit seen = 1'b0;
    start0 = 1'b1;
    rdy0   = 1'b0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      tick();
      start0 = 1'b0;
      rdy0   = (c % 2 == 1);
      if (v0) begin
        if (k < 12) begin
          check("st_rd_a", 32'(a0), exp_a0[k]);
          check("st_rd_b", 32'(b0), exp_b0[k]);
          check("st_tw", 32'(tw0), exp_tw0[k]);
          if (rdy0) begin
            exp_q.push_back({((k / 4) % 2 == 0), 4'(exp_a0[k]), 4'(exp_b0[k])});
            due_q.push_back(c + 2);
            k++;
          end
        end else begin
          check("st_extra_rd", 32'(v0), 0);
        end
      end
      if (due_q.size() > 0 && due_q[0] == c) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("st_wr_valid", 32'(wv0), 1);
        check("st_wr_fields", 32'({wbk0, wa0, wb0}), 32'(e));
        nw++;
      end else begin
        check("st_wr_idle", 32'(wv0), 0);
      end
      if (done0) seen = 1'b1;
    end
    rdy0 = 1'b1;
    check("st_reads", k, 12);
    check("st_writes", nw, 12);
    check("st_done_seen", 32'(seen), 1);
    tick();
  endtask

  task automatic run_u1();
    int k = 0, nw = 0;
    bit seen = 1'b0;
    start1 = 1'b1;
    rdy1   = 1'b1;
    for (int c = 1; c <= 100 && !seen; c++) begin
      tick();
      start1 = 1'b0;
      if (v1) begin
        if (k < 8) begin
          check("u1_rd_a", 32'(a1), exp_a1[k]);
          check("u1_rd_b", 32'(b1), exp_b1[k]);
          check("u1_tw", 32'(tw1), exp_tw1[k]);
        end else begin
          check("u1_extra_rd", 32'(v1), 0);
        end
        k++;
      end
      if (wv1) nw++;
      if (done1) begin
        seen = 1'b1;
        check("u1_final_bank", 32'(fb1), 0);
      end
    end
    check("u1_reads", k, 8);
    check("u1_writes", nw, 8);
    check("u1_done_seen", 32'(seen), 1);
    tick();
  endtask

  initial begin
    #12;
    check_u0_zero("rst");
    check("rst_u1_busy", 32'(busy1), 0);
    check("rst_u1_state", 32'(dbg1), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();

    run_ref(1'b0);
    run_stall();
    run_u1();

    // Abort mid stage 0 with an asynchronous reset.
    start0 = 1'b1;
    rdy0   = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 check_u0_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_u0_zero("post_abort");

    run_ref(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
